sgemm_mul_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one pipelined signed multiplier between NREQ requesters, such as parallel sgemm MAC lanes or address generators. Each requester uses a valid/ready handshake. A tag (requester id) travels alongside each operand pair through a valid/tag shift register matched to the multiplier latency. Results leave on a single response port with global backpressure, which is applied by gating the multiplier's ce.

---
 rtl/sgemm_mul_arb_pkg.sv | 41 ++++
 rtl/sgemm_mul_arb_if.sv | 27 ++
 rtl/sgemm_mul_arb_pipe.sv | 25 ++
 rtl/sgemm_mul_arb.sv | 84 ++++++++
 tb/tb_sgemm_mul_arb.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sgemm_mul_arb_pkg.sv
// Shared constants, pipe-entry type and the round-robin pick function for the
// sgemm_mul_arb multiplier-sharing arbiter.
package sgemm_mul_arb_pkg;

  localparam int NREQ_D  = 4;
  localparam int DW_D    = 63;
  localparam int LAT_D   = 5;
  localparam int MAX_REQ = 8;
  localparam int MAX_IDW = 3;

  typedef struct packed {
    logic               hit;
    logic [MAX_IDW-1:0] idx;
  } pick_t;

  typedef struct packed {
    logic               vld;
    logic [MAX_IDW-1:0] tag;
  } pipe_ent_t;

  // First valid requester at or after ptr, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [MAX_IDW-1:0] ptr,
                                    input int                 n);
    pick_t r;
    int    j;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        j = int'(ptr) + i;
        if (j >= n) j = j - n;
        if (!r.hit && valid[j[MAX_IDW-1:0]]) begin
          r.hit = 1'b1;
          r.idx = j[MAX_IDW-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sgemm_mul_arb_if.sv
// Request/response bundle between the requesters and sgemm_mul_arb.
interface sgemm_mul_arb_if
  import sgemm_mul_arb_pkg::*;
#(
  parameter int NREQ = NREQ_D,
  parameter int IDW  = $clog2(NREQ),
  parameter int DW   = DW_D
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_din0;
  logic [NREQ*DW-1:0] req_din1;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_dout;

  modport master (
    output req_valid, req_din0, req_din1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_dout
  );

  modport slave (
    input  req_valid, req_din0, req_din1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_dout
  );
endinterface

// File: rtl/sgemm_mul_arb_pipe.sv
// ce-gated signed multiplier, LAT register stages, product truncated to DW bits.
module sgemm_mul_arb_pipe
  import sgemm_mul_arb_pkg::*;
#(
  parameter int DW  = DW_D,
  parameter int LAT = LAT_D
) (
  input  logic                 clk,
  input  logic                 ce,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] p
);
  logic signed [DW-1:0] stage_q [LAT];

  // NOTE: data stages carry no reset; the vld bits of the tag pipe qualify them.
  always_ff @(posedge clk) begin
    if (ce) begin
      stage_q[0] <= a * b;
      for (int k = 1; k < LAT; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign p = stage_q[LAT-1];
endmodule

// File: rtl/sgemm_mul_arb.sv
// Round-robin arbiter sharing one pipelined multiplier between NREQ requesters.
// Define SGEMM_MUL_ARB_PERF_EN to add per-requester grant and stall counters.
module sgemm_mul_arb
  import sgemm_mul_arb_pkg::*;
#(
  parameter int NREQ = NREQ_D,
  parameter int IDW  = $clog2(NREQ),
  parameter int DW   = DW_D,
  parameter int LAT  = LAT_D
) (
  input  logic clk,
  input  logic reset,
  sgemm_mul_arb_if.slave bus
`ifdef SGEMM_MUL_ARB_PERF_EN
  ,
  output logic [NREQ*32-1:0] perf_grant_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);
  pick_t                pick;
  logic [IDW-1:0]       win;
  logic [NREQ-1:0]      grant;
  logic [IDW-1:0]       rr_ptr;
  logic                 ce;
  logic                 issue;
  logic signed [DW-1:0] opa;
  logic signed [DW-1:0] opb;
  logic signed [DW-1:0] prod;
  pipe_ent_t            pipe_q [LAT];

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    pick  = rr_pick(MAX_REQ'(bus.req_valid), MAX_IDW'(rr_ptr), NREQ);
    win   = pick.idx[IDW-1:0];
    grant = '0;
    if (pick.hit) grant[win] = 1'b1;
  end

  // A held result at the output freezes the whole pipe, bubbles included.
  assign ce    = ~(pipe_q[LAT-1].vld & ~bus.rsp_ready);
  assign issue = pick.hit & ce;
  assign opa   = bus.req_din0[win*DW +: DW];
  assign opb   = bus.req_din1[win*DW +: DW];

  // Gating with reset keeps req_ready low while the block is held in reset.
  assign bus.req_ready = grant & {NREQ{ce & reset}};

  // Tags are cleared along with vld so rsp_id reads 0 during reset.
  // NOTE: state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
      for (int k = 0; k < LAT; k++) pipe_q[k] <= '0;
    end else if (ce) begin
      if (issue) rr_ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
      pipe_q[0] <= '{vld: issue, tag: pick.idx};
      for (int k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  sgemm_mul_arb_pipe #(.DW(DW), .LAT(LAT)) u_pipe (
    .clk (clk),
    .ce  (ce),
    .a   (opa),
    .b   (opb),
    .p   (prod)
  );

  assign bus.rsp_valid = pipe_q[LAT-1].vld;
  assign bus.rsp_id    = pipe_q[LAT-1].tag[IDW-1:0];
  assign bus.rsp_dout  = prod;

`ifdef SGEMM_MUL_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_grant_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (!ce)   perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (issue) perf_grant_cnt[win*32 +: 32] <= perf_grant_cnt[win*32 +: 32] + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sgemm_mul_arb.sv
// Self-checking bench for sgemm_mul_arb: directed vectors, round-robin order,
// backpressure, reset mid-flight and a queue-based scoreboard over random traffic.
module tb_sgemm_mul_arb;
  import sgemm_mul_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int DW   = 63;
  localparam int LAT  = 5;
  localparam logic [DW-1:0] ALL1 = 63'h7FFF_FFFF_FFFF_FFFF;

  typedef struct {
    int            id;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [DW-1:0]  dout;
    int             cnt;
  } txn_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   m_ptr;
  int   m_issued;
  txn_t sb[$];
  vec_t vecs[6];
  int   obs[$];

  sgemm_mul_arb_if #(.NREQ(NREQ), .IDW(IDW), .DW(DW)) bus ();

`ifdef SGEMM_MUL_ARB_PERF_EN
  logic [NREQ*32-1:0] perf_grant_cnt;
  logic [31:0]        perf_stall_cnt;
`endif

  sgemm_mul_arb #(.NREQ(NREQ), .IDW(IDW), .DW(DW), .LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef SGEMM_MUL_ARB_PERF_EN
    ,
    .perf_grant_cnt (perf_grant_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.req_din0[i*DW +: DW] = a;
    bus.req_din1[i*DW +: DW] = b;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    sb.delete();
    m_ptr = 0;
  endtask

  // Checks one cycle against the scoreboard, then advances it past the clock edge.
  task automatic model_cycle(output logic [NREQ-1:0] g);
    pick_t           pk;
    logic            mvalid;
    logic            mce;
    logic [NREQ-1:0] e;
    logic [DW-1:0]   pa;
    logic [DW-1:0]   pb;
    logic [DW-1:0]   pp;
    #1;
    mvalid = (sb.size() > 0) && (sb[0].cnt == 0);
    mce    = !(mvalid && !bus.rsp_ready);
    pk     = rr_pick(MAX_REQ'(bus.req_valid), MAX_IDW'(m_ptr), NREQ);
    e      = '0;
    if (pk.hit && mce) e[pk.idx[IDW-1:0]] = 1'b1;
    g = e;
    check("req_ready", 64'(bus.req_ready), 64'(e));
    check("rsp_valid", 64'(bus.rsp_valid), 64'(mvalid));
    if (mvalid) begin
      check("rsp_id", 64'(bus.rsp_id), 64'(sb[0].id));
      check("rsp_dout", 64'(bus.rsp_dout), 64'(sb[0].dout));
    end
    if (mvalid && bus.rsp_ready) void'(sb.pop_front());
    if (mce) begin
      foreach (sb[i]) if (sb[i].cnt > 0) sb[i].cnt = sb[i].cnt - 1;
    end
    if (e != '0) begin
      pa = bus.req_din0[int'(pk.idx)*DW +: DW];
      pb = bus.req_din1[int'(pk.idx)*DW +: DW];
      pp = pa * pb;
      sb.push_back('{id: pk.idx[IDW-1:0], dout: pp, cnt: LAT - 1});
      m_ptr = (int'(pk.idx) + 1) % NREQ;
      m_issued++;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_op();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0:       return ALL1;
      1:       return 63'h4000_0000_0000_0000;
      2:       return 63'h3FFF_FFFF_FFFF_FFFF;
      default: return t[DW-1:0];
    endcase
  endfunction

  initial begin
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] rv;
    logic [NREQ-1:0] e;
    int              lat;
    int              cyc;

    errors   = 0;
    checks   = 0;
    m_ptr    = 0;
    m_issued = 0;

    vecs[0] = '{1, 63'd3, 63'h7FFF_FFFF_FFFF_FFF9, 63'h7FFF_FFFF_FFFF_FFEB};
    vecs[1] = '{0, 63'h3FFF_FFFF_FFFF_FFFF, 63'd2, 63'h7FFF_FFFF_FFFF_FFFE};
    vecs[2] = '{3, ALL1, ALL1, 63'd1};
    vecs[3] = '{2, 63'd0, 63'd12345, 63'd0};
    vecs[4] = '{1, 63'h4000_0000_0000_0000, ALL1, 63'h4000_0000_0000_0000};
    vecs[5] = '{0, 63'd100000, 63'd100000, 63'd10000000000};

    // Reset state, with every requester asking.
    reset         = 1'b0;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    bus.req_din0  = '0;
    bus.req_din1  = '0;
    step();
    #1;
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_req_ready", 64'(bus.req_ready), 64'd0);
    check("reset_rsp_id", 64'(bus.rsp_id), 64'd0);
    bus.req_valid = '0;
    reset = 1'b1;
    step();
    step();

    // Directed single-request vectors: grant, latency, id and truncated product.
    for (int n = 0; n < 6; n++) begin
      e = 4'b0001 << vecs[n].id;
      bus.req_valid = e;
      set_op(vecs[n].id, vecs[n].a, vecs[n].b);
      #1;
      check("vec_ready", 64'(bus.req_ready), 64'(e));
      step();
      bus.req_valid = '0;
      lat = 1;
      #1;
      while (!bus.rsp_valid && lat < LAT + 4) begin
        @(posedge clk);
        #2;
        lat++;
      end
      check("vec_latency", 64'(lat), 64'(LAT));
      check("vec_id", 64'(bus.rsp_id), 64'(vecs[n].id));
      check("vec_dout", 64'(bus.rsp_dout), 64'(vecs[n].exp));
      step();
      step();
    end

    // All four valid for 8 cycles starting from rr_ptr=0.
    do_reset();
    obs.delete();
    bus.req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NREQ; i++) set_op(i, DW'(i * 100 + k + 1), DW'(k + 2));
      #1;
      e = 4'b0001 << (k % 4);
      check("rr_grant", 64'(bus.req_ready), 64'(e));
      if (bus.rsp_valid) obs.push_back(int'(bus.rsp_id));
      model_cycle(g);
    end
    bus.req_valid = '0;
    for (int k = 0; k < LAT + 3; k++) begin
      #1;
      if (bus.rsp_valid) obs.push_back(int'(bus.rsp_id));
      model_cycle(g);
    end
    check("rr_rsp_count", 64'(obs.size()), 64'd8);
    for (int k = 0; k < obs.size(); k++) check("rr_rsp_order", 64'(obs[k]), 64'(k % 4));

    // Backpressure: five grants to req2, then a 4-cycle stall on the first result.
    do_reset();
`ifdef SGEMM_MUL_ARB_PERF_EN
    check("perf_clear_grant", 64'(perf_grant_cnt[63:0]), 64'd0);
    check("perf_clear_stall", 64'(perf_stall_cnt), 64'd0);
`endif
    bus.req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      set_op(2, DW'(10 + k), 63'h7FFF_FFFF_FFFF_FFFD);
      model_cycle(g);
    end
    bus.req_valid = 4'b0010;
    set_op(1, 63'd7, 63'd9);
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp_ready", 64'(bus.req_ready), 64'd0);
      check("bp_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp_id", 64'(bus.rsp_id), 64'd2);
      check("bp_dout", 64'(bus.rsp_dout), 64'(63'h7FFF_FFFF_FFFF_FFE2));
      model_cycle(g);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_resume_ready", 64'(bus.req_ready), 64'(4'b0010));
    model_cycle(g);
    bus.req_valid = '0;
    for (int k = 0; k < LAT + 6; k++) model_cycle(g);
`ifdef SGEMM_MUL_ARB_PERF_EN
    check("perf_grant_req2", 64'(perf_grant_cnt[2*32 +: 32]), 64'd5);
    check("perf_grant_req1", 64'(perf_grant_cnt[1*32 +: 32]), 64'd1);
    check("perf_grant_req0", 64'(perf_grant_cnt[0*32 +: 32]), 64'd0);
    check("perf_stall", 64'(perf_stall_cnt), 64'd4);
`endif

    // Reset with three results in flight and rr_ptr left at 3.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      bus.req_valid = 4'b0001 << k;
      set_op(k, DW'(k + 3), DW'(5));
      model_cycle(g);
    end
    bus.req_valid = '1;
    #2;
    reset = 1'b0;
    #1;
    check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("midrst_req_ready", 64'(bus.req_ready), 64'd0);
    check("midrst_rsp_id", 64'(bus.rsp_id), 64'd0);
    step();
    bus.req_valid = '0;
    reset = 1'b1;
    sb.delete();
    m_ptr = 0;
    for (int k = 0; k < LAT + 2; k++) model_cycle(g);
    bus.req_valid = '1;
    #1;
    check("midrst_first_grant", 64'(bus.req_ready), 64'(4'b0001));
    model_cycle(g);
    bus.req_valid = '0;
    for (int k = 0; k < LAT + 2; k++) model_cycle(g);

    // Random traffic against the scoreboard, requesters hold until accepted.
    do_reset();
    m_issued = 0;
    rv  = '0;
    cyc = 0;
    while ((m_issued < 200 || rv != '0 || sb.size() != 0) && cyc < 4000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!rv[i] && m_issued < 200 && $urandom_range(0, 1) == 1) begin
          rv[i] = 1'b1;
          set_op(i, rand_op(), rand_op());
        end
      end
      bus.req_valid = rv;
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      model_cycle(g);
      rv = rv & ~g;
      cyc++;
    end
    check("rand_in_budget", 64'(cyc < 4000), 64'd1);
    check("rand_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
